// File: rtl/sensor_hub_pkg.sv
// Shared definitions for the sensor hub: FSM encoding, ASCII constants, message layout.
// Pure declarations; no timing or flow-control behaviour.
package sensor_hub_pkg;

  typedef enum logic [2:0] {
    IDLE,
    I2C_REQ,
    I2C_WAIT,
    FORMAT,
    SEND
  } state_t;

  localparam logic [7:0] ASCII_T     = 8'h54;
  localparam logic [7:0] ASCII_E_LC  = 8'h65;
  localparam logic [7:0] ASCII_M     = 8'h6D;
  localparam logic [7:0] ASCII_P     = 8'h70;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_E     = 8'h45;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int PREFIX_LEN  = 7;
  localparam int MAX_MSG_LEN = 13;
  localparam int ERR_MSG_LEN = 12;

  // "Temp = " shared by every message
  function automatic logic [7:0] prefix_byte(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = ASCII_T;
      4'd1:    b = ASCII_E_LC;
      4'd2:    b = ASCII_M;
      4'd3:    b = ASCII_P;
      4'd4:    b = ASCII_SP;
      4'd5:    b = ASCII_EQ;
      4'd6:    b = ASCII_SP;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] err_byte(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd7:    b = ASCII_E;
      4'd8:    b = ASCII_R;
      4'd9:    b = ASCII_R;
      4'd10:   b = ASCII_CR;
      4'd11:   b = ASCII_LF;
      default: b = prefix_byte(idx);
    endcase
    return b;
  endfunction

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return {4'h3, d};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary to BCD converter: start loads, done pulses 8 cycles later.
// No backpressure; digits hold until the next start.
module bin2bcd_seq
  import sensor_hub_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin_in,
  output logic       done,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [7:0]  bin_q;
  logic [11:0] bcd_q;
  logic [7:0]  bcd_adj;
  logic [2:0]  iter;
  logic        running;

  // hundreds never exceeds 1 before the last shift, so only tens/ones need adjusting
  always_comb begin
    bcd_adj = bcd_q[7:0];
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q   <= 8'h00;
      bcd_q   <= 12'h000;
      iter    <= 3'd0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bin_q   <= bin_in;
        bcd_q   <= 12'h000;
        iter    <= 3'd0;
        running <= 1'b1;
      end else if (running) begin
        bcd_q <= {bcd_q[10:8], bcd_adj, bin_q[7]};
        bin_q <= {bin_q[6:0], 1'b0};
        iter  <= iter + 3'd1;
        if (iter == 3'd7) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign hund = bcd_q[11:8];
  assign tens = bcd_q[7:4];
  assign ones = bcd_q[3:0];

endmodule

// File: rtl/sensor_poll_sequencer.sv
// Polls the I2C temperature sensor (trigger or timer) and streams "Temp = <v>\r\n" to UART TX.
// Trigger edge to i2c_start: 2 cycles; tx_valid holds each byte stable until tx_ready accepts it.
module sensor_poll_sequencer
  import sensor_hub_pkg::*;
#(
  parameter int POLL_CYCLES        = 1_000_000,
  parameter int I2C_TIMEOUT_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic       auto_en,
  output logic       i2c_start,
  input  logic       i2c_done,
  input  logic       i2c_ack_err,
  input  logic [7:0] i2c_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] err_count
);

  state_t      state, state_n;
  logic        trig_q;
  logic        trig_rise;
  logic        pending;
  logic [31:0] poll_cnt;
  logic        poll_tc;
  logic [31:0] to_cnt;
  logic        neg_q;
  logic        err_flag;
  logic [3:0]  idx;
  logic [3:0]  msg_len;
  logic [7:0]  msg [MAX_MSG_LEN];

  logic        bcd_start;
  logic        bcd_done;
  logic [3:0]  bcd_hund, bcd_tens, bcd_ones;
  logic [7:0]  mag;

  logic        set_err;
  logic        load_msg;
  logic        xfer;
  logic        last_byte;
  logic [7:0]  cur_byte;
  logic [7:0]  build_msg [MAX_MSG_LEN];
  logic [3:0]  build_pos;
  logic [3:0]  build_len;

  assign trig_rise = trigger & ~trig_q;
  assign poll_tc   = auto_en && (poll_cnt == 32'(POLL_CYCLES - 1));
  assign mag       = i2c_data[7] ? (~i2c_data + 8'd1) : i2c_data;

  bin2bcd_seq u_bcd (
    .clk    (clk),
    .rst    (rst),
    .start  (bcd_start),
    .bin_in (mag),
    .done   (bcd_done),
    .hund   (bcd_hund),
    .tens   (bcd_tens),
    .ones   (bcd_ones)
  );

  // The error message is constant, so it is read straight from the package instead of the buffer
  assign cur_byte  = err_flag ? err_byte(idx) : msg[idx];
  assign last_byte = err_flag ? (idx == 4'(ERR_MSG_LEN - 1)) : (idx == msg_len - 4'd1);

  always_comb begin
    state_n   = state;
    i2c_start = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    busy      = (state != IDLE);
    bcd_start = 1'b0;
    set_err   = 1'b0;
    load_msg  = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (pending) state_n = I2C_REQ;
      end
      I2C_REQ: begin
        i2c_start = 1'b1;
        state_n   = I2C_WAIT;
      end
      I2C_WAIT: begin
        if (i2c_done) begin
          if (i2c_ack_err) begin
            set_err = 1'b1;
            state_n = SEND;
          end else begin
            bcd_start = 1'b1;
            state_n   = FORMAT;
          end
        end else if (to_cnt == 32'd1) begin
          set_err = 1'b1;
          state_n = SEND;
        end
      end
      FORMAT: begin
        if (bcd_done) begin
          load_msg = 1'b1;
          state_n  = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = cur_byte;
        if (tx_ready) begin
          xfer = 1'b1;
          if (last_byte) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Message layout: prefix, optional '-', digits without leading zeros, CR LF
  always_comb begin
    for (int i = 0; i < MAX_MSG_LEN; i++) build_msg[i] = 8'h00;
    for (int i = 0; i < PREFIX_LEN; i++) build_msg[i] = prefix_byte(4'(i));
    build_pos = 4'(PREFIX_LEN);
    if (neg_q) begin
      build_msg[build_pos] = ASCII_MINUS;
      build_pos            = build_pos + 4'd1;
    end
    if (bcd_hund != 4'd0) begin
      build_msg[build_pos] = digit_char(bcd_hund);
      build_pos            = build_pos + 4'd1;
    end
    if ((bcd_hund != 4'd0) || (bcd_tens != 4'd0)) begin
      build_msg[build_pos] = digit_char(bcd_tens);
      build_pos            = build_pos + 4'd1;
    end
    build_msg[build_pos]        = digit_char(bcd_ones);
    build_msg[build_pos + 4'd1] = ASCII_CR;
    build_msg[build_pos + 4'd2] = ASCII_LF;
    build_len                   = build_pos + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      trig_q    <= 1'b0;
      pending   <= 1'b0;
      poll_cnt  <= 32'd0;
      to_cnt    <= 32'd0;
      neg_q     <= 1'b0;
      err_flag  <= 1'b0;
      err_count <= 8'h00;
      idx       <= 4'd0;
      msg_len   <= 4'd0;
    end else begin
      state  <= state_n;
      trig_q <= trigger;

      // A new request in the consuming cycle wins, so it is never dropped
      if (trig_rise || poll_tc)           pending <= 1'b1;
      else if (state == IDLE)             pending <= 1'b0;

      if (!auto_en || poll_tc) poll_cnt <= 32'd0;
      else                     poll_cnt <= poll_cnt + 32'd1;

      if (state == I2C_REQ)       to_cnt <= 32'(I2C_TIMEOUT_CYCLES);
      else if (state == I2C_WAIT) to_cnt <= to_cnt - 32'd1;

      if (bcd_start) neg_q <= i2c_data[7];

      if (set_err) begin
        err_flag <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end else if (xfer && last_byte) begin
        err_flag <= 1'b0;
      end

      if (set_err || load_msg) idx <= 4'd0;
      else if (xfer)           idx <= idx + 4'd1;

      if (load_msg) msg_len <= build_len;
    end
  end

  always_ff @(posedge clk) begin
    if (load_msg) begin
      for (int i = 0; i < MAX_MSG_LEN; i++) msg[i] <= build_msg[i];
    end
  end

endmodule

// File: tb/tb_sensor_poll_sequencer.sv
// Bench for sensor_poll_sequencer: table of reads plus merge, poll-period, stall and reset sequences.
module tb_sensor_poll_sequencer;

  localparam int POLL = 1000;
  localparam int TMO  = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       trigger;
  logic       auto_en;
  logic       i2c_start;
  logic       i2c_done;
  logic       i2c_ack_err;
  logic [7:0] i2c_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic [7:0] err_count;

  sensor_poll_sequencer #(.POLL_CYCLES(POLL), .I2C_TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .auto_en(auto_en),
    .i2c_start(i2c_start), .i2c_done(i2c_done), .i2c_ack_err(i2c_ack_err),
    .i2c_data(i2c_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         nack;
    bit         hold;
    string      body;
    int         ecnt;
  } vec_t;

  vec_t       vecs[9];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         start_log[$];
  int         bytes_rx = 0;
  int         start_cnt = 0;
  int         start_cyc = 0;
  int         done_cyc = -1;
  int         first_valid_cyc = -1;
  bit         resp_active = 1'b0;
  logic [7:0] resp_data = 8'h00;
  bit         resp_nack = 1'b0;
  bit         resp_hold = 1'b0;
  string      resp_body = "0";
  int         resp_delay = 3;
  bit         rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push_msg(input string body);
    string pre;
    pre = "Temp = ";
    for (int i = 0; i < pre.len(); i++) exp_q.push_back(pre[i]);
    for (int i = 0; i < body.len(); i++) exp_q.push_back(body[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // I2C slave model: answers each i2c_start and queues the message it should cause
  initial begin
    i2c_done = 1'b0; i2c_ack_err = 1'b0; i2c_data = 8'h00;
    forever begin
      @(negedge clk);
      if (i2c_start && !rst) begin
        start_cnt++;
        start_cyc = cyc;
        start_log.push_back(cyc);
        push_msg(resp_body);
        if (!resp_hold) begin
          resp_active = 1'b1;
          repeat (resp_delay) @(negedge clk);
          i2c_done = 1'b1; i2c_ack_err = resp_nack; i2c_data = resp_data;
          done_cyc = cyc;
          @(negedge clk);
          i2c_done = 1'b0; i2c_ack_err = 1'b0;
          resp_active = 1'b0;
        end
      end
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // UART sink: scoreboard compare plus hold-while-stalled check
  initial begin
    logic       prev_valid, prev_stall;
    logic [7:0] prev_data;
    prev_valid = 1'b0; prev_stall = 1'b0; prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0; prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", tx_valid, 1);
          chk("stall_data", tx_data, prev_data);
        end
        if (tx_valid && !prev_valid) first_valid_cyc = cyc;
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) chk("unexpected_byte", tx_data, 256);
          else                   chk("tx_byte", tx_data, exp_q.pop_front());
          bytes_rx++;
        end
        prev_valid = tx_valid;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0 || resp_active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_idle: busy=%0d bytes_left=%0d after %0d cycles", name, busy, exp_q.size(), n);
    end
  endtask

  task automatic wait_start(input string name, input int base, input int budget);
    int n;
    n = 0;
    while (start_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_start_seen"}, start_cnt - base, 1);
  endtask

  task automatic run_txn(input logic [7:0] d, input bit nack, input bit hold,
                         input string body, input int ecnt, input string name);
    int base, trig_cyc;
    resp_data = d; resp_nack = nack; resp_hold = hold; resp_body = body; resp_delay = 3;
    bytes_rx = 0; first_valid_cyc = -1; done_cyc = -1;
    base = start_cnt;
    @(negedge clk);
    trig_cyc = cyc;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    wait_start(name, base, 20);
    chk({name, "_start_lat"}, start_cyc - trig_cyc, 2);
    wait_idle(name, 800);
    chk({name, "_len"}, bytes_rx, 9 + body.len());
    if (hold)       chk_rng({name, "_timeout_lat"}, first_valid_cyc - start_cyc, TMO, TMO + 2);
    else if (!nack) chk({name, "_format_lat"}, first_valid_cyc - done_cyc, 10);
    chk({name, "_err_count"}, err_count, ecnt);
    chk({name, "_busy_end"}, busy, 0);
  endtask

  initial begin
    int base, n;
    vecs[0] = '{8'h19, 1'b0, 1'b0, "25",   0};
    vecs[1] = '{8'h80, 1'b0, 1'b0, "-128", 0};
    vecs[2] = '{8'h00, 1'b0, 1'b0, "0",    0};
    vecs[3] = '{8'h55, 1'b1, 1'b0, "ERR",  1};
    vecs[4] = '{8'h00, 1'b0, 1'b1, "ERR",  2};
    vecs[5] = '{8'h7F, 1'b0, 1'b0, "127",  2};
    vecs[6] = '{8'hFF, 1'b0, 1'b0, "-1",   2};
    vecs[7] = '{8'h64, 1'b0, 1'b0, "100",  2};
    vecs[8] = '{8'hF6, 1'b0, 1'b0, "-10",  2};

    rst = 1'b1; trigger = 1'b0; auto_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_i2c_start", i2c_start, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_count", err_count, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_txn(vecs[i].data, vecs[i].nack, vecs[i].hold, vecs[i].body, vecs[i].ecnt,
              $sformatf("vec%0d", i));

    rand_ready = 1'b1;
    run_txn(8'h80, 1'b0, 1'b0, $sformatf("%0d", $signed(8'h80)), 2, "stall_a");
    run_txn(8'hD3, 1'b0, 1'b0, $sformatf("%0d", $signed(8'hD3)), 2, "stall_b");
    rand_ready = 1'b0;
    @(negedge clk);

    // Requests during WAIT and SEND merge into a single follow-up read
    base = start_cnt;
    resp_data = 8'h2A; resp_nack = 1'b0; resp_hold = 1'b0; resp_body = "42"; resp_delay = 20;
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
    wait_start("merge", base, 20);
    repeat (2) @(negedge clk);
    trigger = 1'b1; @(negedge clk);
    trigger = 1'b0; @(negedge clk);
    trigger = 1'b1; @(negedge clk);
    trigger = 1'b0;
    n = 0;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("merge_in_send", tx_valid, 1);
    trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
    wait_idle("merge_a", 1500);
    repeat (3) @(negedge clk);
    wait_idle("merge_b", 1500);
    repeat (60) @(negedge clk);
    chk("merge_starts", start_cnt - base, 2);
    chk("merge_busy", busy, 0);
    resp_delay = 3;

    // Auto-poll period
    start_log.delete();
    base = start_cnt;
    resp_data = 8'h19; resp_body = "25";
    @(negedge clk) auto_en = 1'b1;
    n = 0;
    while (start_cnt < base + 3 && n < 3500) begin
      @(negedge clk);
      n++;
    end
    auto_en = 1'b0;
    chk("auto_starts", start_cnt - base, 3);
    if (start_log.size() >= 3) begin
      chk("auto_period_1", start_log[1] - start_log[0], POLL);
      chk("auto_period_2", start_log[2] - start_log[1], POLL);
    end
    wait_idle("auto", 800);

    // Reset in the middle of a message
    resp_data = 8'h19; resp_body = "25"; bytes_rx = 0;
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
    n = 0;
    while (bytes_rx < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_bytes", bytes_rx, 4);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_tx_valid", tx_valid, 0);
    chk("rst_mid_i2c_start", i2c_start, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_err_count", err_count, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_txn(8'h19, 1'b0, 1'b0, "25", 0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
